// File: rtl/traffic_phase_ctrl.sv
// Two-road (NS/EW) intersection phase sequencer with a tick-driven per-phase counter.
// Optional pedestrian walk request is compiled in with `define PED_WALK_EN.
module traffic_phase_ctrl #(
    parameter int NBITS      = 8,
    parameter int T_NS_GREEN = 30,
    parameter int T_EW_GREEN = 20,
    parameter int T_YELLOW   = 4,
    parameter int T_ALLRED   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             ew_sensor,
`ifdef PED_WALK_EN
    input  logic             ped_req,
    output logic             ped_walk,
`endif
    output logic [2:0]       ns_light,
    output logic [2:0]       ew_light,
    output logic [2:0]       phase,
    output logic             phase_done,
    output logic [NBITS-1:0] remaining
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALL_RED1  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALL_RED2  = 3'd5
    } phase_t;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    phase_t           state;
    phase_t           nxt_state;
    logic [NBITS-1:0] cnt;
    logic [NBITS-1:0] nxt_cnt;
    logic [NBITS-1:0] cnt_inc;
    logic [NBITS-1:0] dur_cur;
    logic             demand;

    function automatic logic [NBITS-1:0] dur_of(input phase_t p);
        case (p)
            NS_GREEN:             dur_of = NBITS'(T_NS_GREEN);
            NS_YELLOW, EW_YELLOW: dur_of = NBITS'(T_YELLOW);
            EW_GREEN:             dur_of = NBITS'(T_EW_GREEN);
            default:              dur_of = NBITS'(T_ALLRED);
        endcase
    endfunction

    // Returns {ns_light, ew_light}; anything not an explicit green/yellow is all-red.
    function automatic logic [5:0] lights_of(input phase_t p);
        case (p)
            NS_GREEN:  lights_of = {GREEN,  RED};
            NS_YELLOW: lights_of = {YELLOW, RED};
            EW_GREEN:  lights_of = {RED,    GREEN};
            EW_YELLOW: lights_of = {RED,    YELLOW};
            default:   lights_of = {RED,    RED};
        endcase
    endfunction

`ifdef PED_WALK_EN
    logic ped_pending;
    assign demand = ew_sensor | ped_pending;
`else
    assign demand = ew_sensor;
`endif

    assign dur_cur   = dur_of(state);
    assign cnt_inc   = cnt + 1'b1;
    assign phase     = state;
    assign remaining = dur_cur - cnt;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        nxt_state = state;
        nxt_cnt   = cnt;
        case (state)
            NS_GREEN, NS_YELLOW, ALL_RED1, EW_GREEN, EW_YELLOW, ALL_RED2: begin
                if (tick) begin
                    if (cnt_inc == dur_cur) begin
                        nxt_cnt = '0;
                        case (state)
                            // NS green only yields when someone is waiting; otherwise it re-arms.
                            NS_GREEN:  nxt_state = demand ? NS_YELLOW : NS_GREEN;
                            NS_YELLOW: nxt_state = ALL_RED1;
                            ALL_RED1:  nxt_state = EW_GREEN;
                            EW_GREEN:  nxt_state = EW_YELLOW;
                            EW_YELLOW: nxt_state = ALL_RED2;
                            default:   nxt_state = NS_GREEN;
                        endcase
                    end else begin
                        nxt_cnt = cnt_inc;
                    end
                end
            end
            default: begin
                nxt_state = ALL_RED2;
                nxt_cnt   = '0;
            end
        endcase
    end

    // Lamps are decoded from the next phase so lamps, phase and phase_done move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ALL_RED2;
            cnt        <= '0;
            phase_done <= 1'b0;
            ns_light   <= RED;
            ew_light   <= RED;
`ifdef PED_WALK_EN
            ped_pending <= 1'b0;
            ped_walk    <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state                  <= nxt_state;
            cnt                    <= nxt_cnt;
            phase_done             <= (nxt_state != state);
            {ns_light, ew_light}   <= lights_of(nxt_state);
`ifdef PED_WALK_EN
            if (nxt_state == EW_GREEN && state != EW_GREEN) begin
                ped_walk    <= ped_pending;
                ped_pending <= ped_req;
            end else begin
                ped_pending <= ped_pending | ped_req;
                if (state == EW_GREEN && nxt_state != EW_GREEN)
                    ped_walk <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized self-checking bench for traffic_phase_ctrl against a tick/elapsed-time phase model.
// Build with +define+PED_WALK_EN to also exercise the pedestrian request path.
module tb_traffic_phase_ctrl;

    localparam int NBITS = 8;
    localparam int TNG   = 5;
    localparam int TEG   = 3;
    localparam int TY    = 2;
    localparam int TAR   = 1;

    logic             clk;
    logic             rst_n;
    logic             tick;
    logic             ew_sensor;
    logic             ped_req;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;
    logic [2:0]       phase;
    logic             phase_done;
    logic [NBITS-1:0] remaining;
`ifdef PED_WALK_EN
    logic             ped_walk;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: phase number plus ticks elapsed in it.
    int mph;
    int mel;
    int mdone;
    int mpend;
    int mwalk;
    int done_cnt;

    traffic_phase_ctrl #(
        .NBITS(NBITS), .T_NS_GREEN(TNG), .T_EW_GREEN(TEG), .T_YELLOW(TY), .T_ALLRED(TAR)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tick(tick),
        .ew_sensor(ew_sensor),
`ifdef PED_WALK_EN
        .ped_req(ped_req),
        .ped_walk(ped_walk),
`endif
        .ns_light(ns_light),
        .ew_light(ew_light),
        .phase(phase),
        .phase_done(phase_done),
        .remaining(remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int mdur(input int p);
        case (p)
            0:       return TNG;
            1, 4:    return TY;
            3:       return TEG;
            default: return TAR;
        endcase
    endfunction

    function automatic logic [2:0] ns_exp(input int p);
        case (p)
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_exp(input int p);
        case (p)
            3:       return 3'b001;
            4:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic model_reset();
        mph = 5; mel = 0; mdone = 0; mpend = 0; mwalk = 0;
    endtask

    task automatic model_clk();
        int prev;
        int dmd;
        prev  = mph;
        mdone = 0;
        dmd   = int'(ew_sensor);
`ifdef PED_WALK_EN
        dmd   = dmd | mpend;
`endif
        if (tick) begin
            mel++;
            if (mel == mdur(mph)) begin
                mel = 0;
                if (mph != 0 || dmd != 0) begin
                    mph   = (mph + 1) % 6;
                    mdone = 1;
                end
            end
        end
        if (mph == 3 && prev != 3) begin
            mwalk = mpend;
            mpend = int'(ped_req);
        end else begin
            mpend = mpend | int'(ped_req);
            if (prev == 3 && mph != 3) mwalk = 0;
        end
    endtask

    task automatic compare();
        check("phase",      32'(phase),      32'(mph));
        check("ns_light",   32'(ns_light),   32'(ns_exp(mph)));
        check("ew_light",   32'(ew_light),   32'(ew_exp(mph)));
        check("phase_done", 32'(phase_done), 32'(mdone));
        check("remaining",  32'(remaining),  32'(mdur(mph) - mel));
        check("ns_onehot",  32'($onehot(ns_light)), 32'd1);
        check("ew_onehot",  32'($onehot(ew_light)), 32'd1);
        check("no_conflict", 32'(ns_light != 3'b100 && ew_light != 3'b100), 32'd0);
`ifdef PED_WALK_EN
        check("ped_walk",   32'(ped_walk),   32'(mwalk));
`endif
    endtask

    // One clock: inputs already driven; advance the model on the edge, sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_clk();
        #1;
        compare();
        if (phase_done) done_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; ew_sensor = 1'b0; ped_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();

        // Full cycle with constant demand: 14 clk period, six phase_done pulses.
        tick = 1'b1; ew_sensor = 1'b1;
        #2 rst_n = 1'b1;
        done_cnt = 0;
        repeat (14) step();
        check("period_pulses", 32'(done_cnt), 32'd6);
        check("period_end_phase", 32'(phase), 32'd5);
        repeat (14) step();

        // No demand: NS green holds and re-arms without pulsing.
        ew_sensor = 1'b0;
        for (int i = 0; i < 20 && phase != 3'd0; i++) step();
        check("reach_ns_green", 32'(phase), 32'd0);
        done_cnt = 0;
        repeat (20) step();
        check("no_demand_pulses", 32'(done_cnt), 32'd0);
        check("no_demand_phase", 32'(phase), 32'd0);
        for (int i = 0; i < 10 && remaining != 3; i++) step();
        check("reach_remaining3", 32'(remaining), 32'd3);
        ew_sensor = 1'b1;
        repeat (2) step();
        check("demand_hold2", 32'(phase), 32'd0);
        step();
        check("demand_yellow", 32'(phase), 32'd1);

        // Tick gating: every 4th clk, then frozen.
        for (int i = 0; i < 56; i++) begin
            tick = (i % 4 == 0);
            step();
        end
        tick = 1'b0;
        repeat (50) step();

        // Asynchronous reset in the middle of EW green.
        tick = 1'b1;
        for (int i = 0; i < 40 && phase != 3'd3; i++) step();
        check("reach_ew_green", 32'(phase), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        #2 rst_n = 1'b1;
        repeat (14) step();

`ifdef PED_WALK_EN
        // Pedestrian request alone drives exactly one EW phase with walk lit.
        ew_sensor = 1'b0;
        for (int i = 0; i < 20 && phase != 3'd0; i++) step();
        check("ped_reach_ns_green", 32'(phase), 32'd0);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        begin
            int walk_cnt;
            int ew_seen;
            walk_cnt = 0;
            for (int i = 0; i < 30; i++) begin
                step();
                if (ped_walk) walk_cnt++;
            end
            check("ped_walk_len", 32'(walk_cnt), 32'(TEG));
            ew_seen = 0;
            for (int i = 0; i < 30; i++) begin
                step();
                if (phase == 3'd3) ew_seen++;
            end
            check("ped_no_repeat", 32'(ew_seen), 32'd0);
        end
`endif

        // Random tick/sensor traffic with the safety checks applied every clk.
        for (int i = 0; i < 10000; i++) begin
            tick      = ($urandom_range(0, 3) != 0);
            ew_sensor = ($urandom_range(0, 3) == 0);
            ped_req   = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
